// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   state_t   : receiver FSM state encoding (PARITY only reachable when
//               UART_RX_PARITY_EN is defined)
//   DATA_W    : data bits per frame
//   LINE_IDLE : idle level of the serial line
package uart_pkg;

    localparam int   DATA_W    = 8;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: minimal Avalon-MM read-only slave bus for the UART receiver.
//   avalon_read        : single-cycle read strobe (master -> slave)
//   avalon_readdata    : holding register contents (slave -> master)
//   avalon_waitrequest : always 0, zero-latency reads (slave -> master)
interface uart_rx_if;
    import uart_pkg::*;

    logic              avalon_read;
    logic [DATA_W-1:0] avalon_readdata;
    logic              avalon_waitrequest;

    modport master (
        output avalon_read,
        input  avalon_readdata,
        input  avalon_waitrequest
    );

    modport slave (
        input  avalon_read,
        output avalon_readdata,
        output avalon_waitrequest
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable bit-period down-counter, shared by RX and TX.
//   clk      : system clock
//   rst      : asynchronous reset, active-low (counter clears to 0)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load
//   cnt_zero : counter currently holds zero
// The counter parks at zero rather than wrapping, so an idle receiver
// leaves it quiet.
module uart_baud_cnt #(
    parameter int N_LOG = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [N_LOG-1:0] load_val,
    output logic             cnt_zero
);

    logic [N_LOG-1:0] cnt_q;
    logic [N_LOG-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined).
// Deserialises uart_rxd into a one-byte holding register read through a
// minimal Avalon-MM slave.
//   clk         : system clock
//   rst         : asynchronous reset, active-low
//   uart_rxd    : serial input, idle high, asynchronous to clk
//   avalon      : Avalon-MM read slave (read strobe, readdata, waitrequest)
//   status_irq  : unread byte available
//   status_err  : sticky error (framing, overrun, parity)
//   status_busy : frame reception in progress
// Build option: UART_RX_PARITY_EN adds an even-parity bit after the data.
module uart_rx
    import uart_pkg::*;
#(
    parameter int N_BIT = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    uart_rx_if.slave    avalon,
    output logic        status_irq,
    output logic        status_err,
    output logic        status_busy
);

    localparam int N_LOG = $clog2(N_BIT);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [N_LOG-1:0] HALF_BIT = N_LOG'(N_BIT / 2 - 1);
    localparam logic [N_LOG-1:0] FULL_BIT = N_LOG'(N_BIT - 1);

    logic              sync1_q;
    logic              rxd_s_q;
    logic              rxd_prev_q;
    logic              rxd_fall;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              irq_q, irq_d;
    logic              err_q, err_d;
    logic              cnt_load;
    logic [N_LOG-1:0]  cnt_load_val;
    logic              cnt_zero;
`ifdef UART_RX_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    // Two-flop synchroniser plus edge register; all reset to the idle
    // level so releasing reset never fabricates a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= LINE_IDLE;
            rxd_s_q    <= LINE_IDLE;
            rxd_prev_q <= LINE_IDLE;
        end else begin
            sync1_q    <= uart_rxd;
            rxd_s_q    <= sync1_q;
            rxd_prev_q <= rxd_s_q;
        end
    end

    assign rxd_fall = rxd_prev_q & ~rxd_s_q;

    uart_baud_cnt #(.N_LOG(N_LOG)) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .cnt_zero (cnt_zero)
    );

    // Next-state logic. A read clears the flags first; a byte completing
    // in the same cycle then overrides, so completion wins.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        irq_d        = irq_q;
        err_d        = err_q;
        cnt_load     = 1'b0;
        cnt_load_val = FULL_BIT;
`ifdef UART_RX_PARITY_EN
        par_err_d    = par_err_q;
`endif

        if (avalon.avalon_read) begin
            irq_d = 1'b0;
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rxd_fall) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = HALF_BIT;
                    state_d      = START;
                end
            end
            START: begin
                if (cnt_zero) begin
                    if (rxd_s_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_load  = 1'b1;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shift_d  = {rxd_s_q, shift_q[DATA_W-1:1]};
                    cnt_load = 1'b1;
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_zero) begin
                    par_err_d = ^{shift_q, rxd_s_q};
                    cnt_load  = 1'b1;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_zero) begin
                    // Byte is delivered even on a framing error; irq_q
                    // still high means the previous byte was never read.
                    hold_d = shift_q;
                    irq_d  = 1'b1;
                    err_d  = err_d | ~rxd_s_q | irq_q;
`ifdef UART_RX_PARITY_EN
                    err_d  = err_d | par_err_q;
`endif
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            irq_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            irq_q     <= irq_d;
            err_q     <= err_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign avalon.avalon_readdata    = hold_q;
    assign avalon.avalon_waitrequest = 1'b0;
    assign status_irq  = irq_q;
    assign status_err  = err_q;
    assign status_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with a short bit period.
// Expected completions are queued as frames are sent; a monitor pops and
// compares each time status_busy falls (frame done or glitch rejected).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int N_BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 10;
`else
    localparam int FRAME_BITS = 9;
`endif
    // Edges counted from 1, starting with the first clk edge after the pin falls.
    localparam int EXP_IRQ_EDGE = 2 + N_BIT / 2 + FRAME_BITS * N_BIT + 1;

    typedef struct {
        logic        glitch;
        logic [7:0]  data;
        logic        irq;
        logic        err;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rxd = 1'b1;
    logic status_irq;
    logic status_err;
    logic status_busy;
    logic busy_prev;
    int   total = 0;
    int   bad = 0;
    int   cycles;
    int   busy_cnt;
    exp_t sb[$];
`ifdef UART_RX_PARITY_EN
    logic flip_parity = 1'b0;
`endif

    uart_rx_if bus ();

    uart_rx #(.N_BIT(N_BIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rxd    (uart_rxd),
        .avalon      (bus),
        .status_irq  (status_irq),
        .status_err  (status_err),
        .status_busy (status_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic glitch, input logic [7:0] data,
                                input logic irq, input logic err, input string name);
        exp_t e;
        e.glitch = glitch;
        e.data   = data;
        e.irq    = irq;
        e.err    = err;
        e.name   = name;
        sb.push_back(e);
    endtask

    // Hold one bit on the line for one bit period; called on a negedge.
    task automatic driveBit(input logic b);
        uart_rxd = b;
        repeat (N_BIT) @(negedge clk);
    endtask

    // One frame; the line is left at the stop-bit level so frames chain
    // back-to-back.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
        driveBit(^data ^ flip_parity);
`endif
        driveBit(stop_bit);
    endtask

    task automatic readPulse();
        @(negedge clk);
        bus.avalon_read = 1'b1;
        @(negedge clk);
        bus.avalon_read = 1'b0;
    endtask

    // Scoreboard monitor.
    initial begin
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && busy_prev && !status_busy) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_completion: got data %0h, wanted none",
                             bus.avalon_readdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (!e.glitch) checkOutput({e.name, "_data"}, 32'(bus.avalon_readdata), 32'(e.data));
                    checkOutput({e.name, "_irq"}, 32'(status_irq), 32'(e.irq));
                    checkOutput({e.name, "_err"}, 32'(status_err), 32'(e.err));
                end
            end
            busy_prev = status_busy;
        end
    end

    initial begin
        bus.avalon_read = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("reset_irq", 32'(status_irq), 32'd0);
        checkOutput("reset_err", 32'(status_err), 32'd0);
        checkOutput("reset_busy", 32'(status_busy), 32'd0);
        checkOutput("reset_data", 32'(bus.avalon_readdata), 32'h00);
        checkOutput("reset_waitreq", 32'(bus.avalon_waitrequest), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Clean 0x55 with latency measurement.
        pushExpected(1'b0, 8'h55, 1'b1, 1'b0, "f55");
        fork
            applyStimulus(8'h55, 1'b1);
            begin
                wait (uart_rxd == 1'b0);
                cycles = 0;
                for (int k = 0; k < 400; k++) begin
                    @(posedge clk);
                    cycles++;
                    #1;
                    if (status_irq) break;
                end
            end
        join
        uart_rxd = 1'b1;
        checkOutput("f55_latency", 32'(cycles), 32'(EXP_IRQ_EDGE));
        readPulse();
        checkOutput("f55_read_irq", 32'(status_irq), 32'd0);

        // 0xA3 then a read pulse.
        pushExpected(1'b0, 8'hA3, 1'b1, 1'b0, "fA3");
        applyStimulus(8'hA3, 1'b1);
        uart_rxd = 1'b1;
        @(negedge clk);
        bus.avalon_read = 1'b1;
        #1;
        checkOutput("fA3_readdata", 32'(bus.avalon_readdata), 32'hA3);
        checkOutput("fA3_irq_during_read", 32'(status_irq), 32'd1);
        @(negedge clk);
        bus.avalon_read = 1'b0;
        checkOutput("fA3_irq_after_read", 32'(status_irq), 32'd0);

        // 0x0F with framing error.
        pushExpected(1'b0, 8'h0F, 1'b1, 1'b1, "f0F");
        applyStimulus(8'h0F, 1'b0);
        uart_rxd = 1'b1;
        readPulse();
        checkOutput("f0F_read_irq", 32'(status_irq), 32'd0);
        checkOutput("f0F_read_err", 32'(status_err), 32'd0);

        // Back-to-back 0x11, 0x22 without a read: overrun.
        pushExpected(1'b0, 8'h11, 1'b1, 1'b0, "f11");
        pushExpected(1'b0, 8'h22, 1'b1, 1'b1, "f22");
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        uart_rxd = 1'b1;
        readPulse();
        checkOutput("f22_read_err", 32'(status_err), 32'd0);

        // 4-cycle low glitch.
        pushExpected(1'b1, 8'h00, 1'b0, 1'b0, "glitch");
        @(negedge clk);
        uart_rxd = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (status_busy) busy_cnt++;
            if (k == 3) uart_rxd = 1'b1;
        end
        checkOutput("glitch_busy_width", 32'(busy_cnt), 32'(N_BIT / 2));

        // Reset in the middle of the data bits of 0x77.
        @(negedge clk);
        fork
            applyStimulus(8'h77, 1'b1);
            begin
                repeat (4 * N_BIT) @(negedge clk);
                rst = 1'b0;
                #1;
                checkOutput("midrst_busy", 32'(status_busy), 32'd0);
                checkOutput("midrst_irq", 32'(status_irq), 32'd0);
                checkOutput("midrst_err", 32'(status_err), 32'd0);
                checkOutput("midrst_data", 32'(bus.avalon_readdata), 32'h00);
            end
        join
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        pushExpected(1'b0, 8'h3C, 1'b1, 1'b0, "f3C");
        applyStimulus(8'h3C, 1'b1);
        uart_rxd = 1'b1;

`ifdef UART_RX_PARITY_EN
        readPulse();
        flip_parity = 1'b1;
        pushExpected(1'b0, 8'h01, 1'b1, 1'b1, "f01_par");
        applyStimulus(8'h01, 1'b1);
        uart_rxd = 1'b1;
        flip_parity = 1'b0;
`endif

        repeat (5) @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Standalone UART receiver: the receive direction of the board's UART path. Counterpart to the button/switch-driven transmit path in the DE1 top level.
- Deserialises 8N1 frames (8E1 optional) from `uart_rxd` into a one-byte holding register.
- Exposes the holding register through a minimal Avalon-MM read slave, with status flags for LEDs and interrupts.

Parameters:
- N_BIT, 2500, bit period in clk cycles (FRQ/BAUDRATE; 24 MHz / 9600). Minimum legal value 4.
- N_LOG, $clog2(N_BIT), width of the bit-period counter (derived; do not override).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- uart_rxd  input  1  serial input, idle high, asynchronous to clk
- avalon_read  input  1  single-cycle read strobe
- avalon_readdata  output  8  holding register contents
- avalon_waitrequest  output  1  constant 0
- status_irq  output  1  unread byte available
- status_err  output  1  sticky error: framing, overrun or parity
- status_busy  output  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset (rst=0, async) state:
  - state=IDLE, counters=0, holding register=8'h00.
  - status_irq=0, status_err=0, status_busy=0.
  - Both synchroniser flops=1.
- Reset mid-frame aborts the frame immediately; no partial byte is ever loaded.
- Input path:
  - 2-flop synchroniser on uart_rxd, giving rxd_s.
  - An edge detect register gives the falling edge of rxd_s.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE. PARITY is inserted between DATA and STOP when the option is enabled.
- IDLE: on a falling edge of rxd_s, load cnt=N_BIT/2-1 and go to START.
- START:
  - cnt decrements each cycle. At cnt==0, sample rxd_s.
  - If rxd_s=1 (glitch): return to IDLE; no flags change.
  - Otherwise load cnt=N_BIT-1, bit index=0, go to DATA.
- DATA:
  - At each cnt==0, sample rxd_s into the shift register LSB-first and reload cnt=N_BIT-1.
  - After bit index 7, go to STOP (or PARITY).
- STOP: at cnt==0, sample the stop bit, then:
  - Load the holding register with the shift register (the byte is delivered even with a framing error).
  - Set status_irq.
  - If stop bit=0 (framing error), set status_err.
  - If status_irq was already 1 (overrun), overwrite the old byte and set status_err.
  - Return to IDLE. A new start edge is accepted from the next cycle, so back-to-back frames are handled with no gap.
- Timing:
  - Sample points fall at mid-bit.
  - The stop-bit sample occurs 2 + N_BIT/2 + 9*N_BIT cycles after the rxd falling edge at the pin.
  - Flags and the holding register update on the clock edge of that sample.
- avalon_readdata is combinational from the holding register (zero read latency).
- avalon_read=1 clears status_irq and status_err on the next edge.
- Simultaneous read and byte completion: completion wins. New data is loaded and status_irq stays 1. status_err takes that frame's error value, not a cleared value.
- status_busy=1 in every state other than IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA. It samples at mid-bit and checks even parity over data plus parity bit.
  - On mismatch, status_err is set at STOP completion.
  - Frame is 8E1; stop sample moves to 2 + N_BIT/2 + 10*N_BIT cycles.
- Undefined: 8N1 only; no PARITY state and no parity logic is synthesised.

Decomposition:
- Package uart_pkg holds:
  - State encoding typedef: IDLE, START, DATA, PARITY, STOP.
  - DATA_W=8.
  - Idle line level constant 1'b1.
- Sub-module uart_baud_cnt:
  - Loadable down-counter of width N_LOG with load value input and zero flag.
  - Shared later with the transmitter.
- The synchroniser stays inline.

Test Plan (N_BIT=16 in simulation):
- Frame 0x55 with stop=1 -> status_irq rises at 2+8+144 cycles after the falling edge; readdata=8'h55; status_err=0.
- Frame 0xA3, then avalon_read pulse -> readdata=8'hA3 during the read; status_irq=0 on the next cycle.
- Frame 0x0F with stop bit=0 -> readdata=8'h0F; status_irq=1; status_err=1; a read clears both.
- Frames 0x11 then 0x22 back-to-back with no read -> readdata=8'h22; status_err=1 (overrun).
- 4-cycle low glitch on rxd -> FSM returns to IDLE; status_irq and status_err stay 0; busy pulses for N_BIT/2 cycles.
- rst asserted mid-DATA of frame 0x77 -> all outputs reset immediately; next clean frame 0x3C received correctly.
- With UART_RX_PARITY_EN: 0x01 with parity=0 -> status_err=1.
